dm_stage: RTL

Data-memory stage controller. It consumes the ALU/DM pipeline register outputs and drives a single-outstanding req/ack data-memory port for loads and stores. It stalls the ALU/DM register while an access is in flight, then registers results into the DM/RW pipeline outputs. Non-memory instructions pass through in one cycle with no stall.

---
 rtl/dm_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dm_stage.sv
// Data-memory stage controller: drives a single-outstanding req/ack memory port for
// loads and stores, stalls the ALU/DM register while an access is in flight, and
// registers results into the DM/RW pipeline outputs.
`timescale 1ns/1ps

module dm_stage #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_DM,
  input  logic [31:0] pc_DM,
  input  logic        is_Ld_DM,
  input  logic        is_St_DM,
  input  logic [31:0] aluResult_DM,
  input  logic [31:0] op2_DM,
  input  logic [4:0]  rd_DM,
  input  logic        isWb_DM,
  input  logic        isCall_DM,
  output logic        stall_ALUDM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] inst_RW,
  output logic [31:0] pc_RW,
  output logic [31:0] aluResult_RW,
  output logic [31:0] ldResult_RW,
  output logic [4:0]  rd_RW,
  output logic        isWb_RW,
  output logic        isLd_RW,
  output logic        isCall_RW,
  output logic        mem_err,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] count;
  logic [31:0] data_q;
  logic        memop;
  logic        ld_only;
  logic        pass_through;

  // A load that is also flagged as a store is treated as a store.
  assign memop   = is_Ld_DM | is_St_DM;
  assign ld_only = is_Ld_DM & ~is_St_DM;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_next   = state;
    stall_ALUDM  = 1'b0;
    pass_through = 1'b0;
    unique case (state)
      IDLE: begin
        if (memop) begin
          stall_ALUDM = 1'b1;
          state_next  = BUSY;
        end else begin
          pass_through = 1'b1;
        end
      end
      BUSY: begin
        stall_ALUDM = 1'b1;
        if (mem_ack || count == LAST_COUNT) state_next = DONE;
      end
      DONE: begin
        pass_through = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Memory port, timeout counter and captured load data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      data_q    <= '0;
      mem_err   <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memop) begin
            mem_req   <= 1'b1;
            mem_we    <= is_St_DM;
            mem_addr  <= {aluResult_DM[31:2], 2'b00};
            mem_wdata <= op2_DM;
            count     <= '0;
            if (|aluResult_DM[1:0]) misalign <= 1'b1;
          end
        end
        BUSY: begin
          // An ack arriving on the timeout cycle still counts as a normal completion.
          if (mem_ack) begin
            mem_req <= 1'b0;
            data_q  <= mem_rdata;
          end else if (count == LAST_COUNT) begin
            mem_req <= 1'b0;
            data_q  <= ERR_DATA;
            mem_err <= 1'b1;
          end else begin
            count <= count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // DM/RW register: copies the DM inputs when the ALU/DM register advances, else a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_RW      <= '0;
      pc_RW        <= '0;
      aluResult_RW <= '0;
      ldResult_RW  <= '0;
      rd_RW        <= '0;
      isWb_RW      <= 1'b0;
      isLd_RW      <= 1'b0;
      isCall_RW    <= 1'b0;
    end else if (pass_through) begin
      inst_RW      <= inst_DM;
      pc_RW        <= pc_DM;
      aluResult_RW <= aluResult_DM;
      ldResult_RW  <= (state == DONE && ld_only) ? data_q : 32'h0;
      rd_RW        <= rd_DM;
      isWb_RW      <= isWb_DM;
      isLd_RW      <= (state == DONE) && ld_only;
      isCall_RW    <= isCall_DM;
    end else begin
      isWb_RW   <= 1'b0;
      isLd_RW   <= 1'b0;
      isCall_RW <= 1'b0;
    end
  end

endmodule
